// File: rtl/divider_8bit.sv
// -----------------------------------------------------------------------------
// divider_8bit
// Sequential 8-bit restoring divider producing one quotient bit per clock.
// It sits beside the ALU multiplier, uses the same operand convention, and
// talks to the sequencer through a start/busy/done handshake.
//
// Configuration macro: DIVIDER_SIGNED_EN
//   defined   : divMode = 1 selects two's-complement signed division
//               (truncation toward zero, remainder takes the dividend's sign),
//               and overflow flags -128 / -1.
//   undefined : every division is unsigned, divMode is ignored and overflow
//               is tied low. Latency is the same in both builds.
// -----------------------------------------------------------------------------
module divider_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       divMode,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       busy,
    output logic       done,
    output logic       divByZero,
    output logic       overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    // Partial remainder; after each step it is below the divisor, so bit 8
    // only matters transiently inside the trial subtraction.
    logic [8:0] rem_q,   rem_d;
    // Dividend magnitude: its bits shift out of the top while quotient bits
    // shift in at the bottom, so after eight steps it holds the quotient.
    // For a zero divisor it keeps the raw dividend for the remainder output.
    logic [7:0] dvd_q,   dvd_d;
    logic [7:0] dvs_q,   dvs_d;
    logic       zero_q,  zero_d;

    logic [7:0] q_q,     q_d;
    logic [7:0] r_q,     r_d;
    logic       done_q,  done_d;
    logic       dbz_q,   dbz_d;

    logic [7:0] a_mag, b_mag;
    logic [7:0] q_fix, r_fix;
    logic [8:0] rem_shift;
    logic [9:0] trial;

    logic       unused_rem_msb;
    assign unused_rem_msb = rem_q[8];

`ifdef DIVIDER_SIGNED_EN
    logic mode_q, mode_d;
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovf_q,  ovf_d;

    // Operand magnitudes; 0x80 negates to itself, which reads as 128 unsigned.
    always_comb begin
        a_mag = (divMode & A[7]) ? (~A + 8'd1) : A;
        b_mag = (divMode & B[7]) ? (~B + 8'd1) : B;
    end

    // Sign restoration of the magnitude results.
    always_comb begin
        q_fix = qneg_q ? (~dvd_q + 8'd1)      : dvd_q;
        r_fix = rneg_q ? (~rem_q[7:0] + 8'd1) : rem_q[7:0];
    end
`else
    logic unused_div_mode;
    assign unused_div_mode = divMode;

    // Unsigned-only build: operands and results pass straight through.
    always_comb begin
        a_mag = A;
        b_mag = B;
        q_fix = dvd_q;
        r_fix = rem_q[7:0];
    end
`endif

    // One restoring step: shift {rem, dvd} left and trial-subtract the divisor.
    always_comb begin
        rem_shift = {rem_q[7:0], dvd_q[7]};
        trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        mode_d  = mode_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = 4'd0;
                    rem_d   = 9'd0;
                    zero_d  = (B == 8'd0);
                    dvs_d   = b_mag;
                    dvd_d   = (B == 8'd0) ? A : a_mag;
`ifdef DIVIDER_SIGNED_EN
                    mode_d  = divMode;
                    qneg_d  = divMode & (A[7] ^ B[7]);
                    rneg_d  = divMode & A[7];
`endif
                    state_d = (B == 8'd0) ? S_FIX : S_CALC;
                end
            end

            S_CALC: begin
                if (trial[9]) begin
                    rem_d = rem_shift;
                    dvd_d = {dvd_q[6:0], 1'b0};
                end else begin
                    rem_d = trial[8:0];
                    dvd_d = {dvd_q[6:0], 1'b1};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (zero_q) begin
                    q_d   = 8'hFF;
                    r_d   = dvd_q;
                    dbz_d = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                    ovf_d = 1'b0;
`endif
                end else begin
                    q_d   = q_fix;
                    r_d   = r_fix;
                    dbz_d = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    // A positive signed quotient of magnitude 128 can only
                    // come from -128 / -1; it wraps to 0x80.
                    ovf_d = mode_q & ~qneg_q & dvd_q[7];
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rem_q   <= 9'd0;
            dvd_q   <= 8'd0;
            dvs_q   <= 8'd0;
            zero_q  <= 1'b0;
            q_q     <= 8'd0;
            r_q     <= 8'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            mode_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            mode_q  <= mode_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Q         = q_q;
    assign R         = r_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign divByZero = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    assign overflow  = ovf_q;
`else
    assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_divider_8bit.sv
// -----------------------------------------------------------------------------
// tb_divider_8bit
// Bench for divider_8bit. A cycle-level reference model computes results with
// plain integer division and tracks the expected latency; a compare process
// checks every output against it on each falling edge. Directed operations
// also pin the results and latency against hand-computed constants.
// Honours DIVIDER_SIGNED_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_divider_8bit;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [7:0] A       = 8'd0;
    logic [7:0] B       = 8'd0;
    logic       divMode = 1'b0;
    logic [7:0] Q, R;
    logic       busy, done, divByZero, overflow;

    divider_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .divMode   (divMode),
        .Q         (Q),
        .R         (R),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } res_t;

    // Reference arithmetic straight from the divider's definition.
    function automatic res_t model_div(input logic [7:0] a, input logic [7:0] b, input logic mode);
        res_t res;
        int   sa;
        int   sb;
        logic signed_op;
        res = '0;
`ifdef DIVIDER_SIGNED_EN
        signed_op = mode;
`else
        signed_op = 1'b0 & mode;
`endif
        if (b == 8'd0) begin
            res.q  = 8'hFF;
            res.r  = a;
            res.dz = 1'b1;
        end else if (signed_op) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -128 && sb == -1) begin
                res.q   = 8'h80;
                res.r   = 8'h00;
                res.ovf = 1'b1;
            end else begin
                res.q = 8'(sa / sb);
                res.r = 8'(sa % sb);
            end
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Cycle model: remaining cycles until done, pending result, visible outputs.
    int   m_cnt;
    res_t m_pend;
    res_t m_out;
    logic m_done;
    logic m_busy;

    assign m_busy = (m_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_pend <= '0;
            m_out  <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_out  <= m_pend;
                end
            end else if (start) begin
                m_pend <= model_div(A, B, divMode);
                m_cnt  <= (B == 8'd0) ? 1 : 9;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        check("busy",      busy,      m_busy);
        check("done",      done,      m_done);
        check("Q",         Q,         m_out.q);
        check("R",         R,         m_out.r);
        check("divByZero", divByZero, m_out.dz);
        check("overflow",  overflow,  m_out.ovf);
    end

    // Issue one division at a falling edge and check it against literals.
    // repulse > 0 re-asserts start with other operands while busy.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic mode, input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eovf, input int elat, input int repulse);
        int lat;
        bit got;
        A       = a;
        B       = b;
        divMode = mode;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        A       = 8'($urandom);
        B       = 8'($urandom);
        divMode = 1'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            if (repulse != 0 && lat == repulse) begin
                start = 1'b1;
                A     = 8'h10;
                B     = 8'h02;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", tag);
        end else begin
            check({tag, "_lat"},  8'(lat), 8'(elat));
            check({tag, "_Q"},    Q,        eq);
            check({tag, "_R"},    R,        er);
            check({tag, "_dz"},   divByZero, edz);
            check({tag, "_ovf"},  overflow,  eovf);
            check({tag, "_busy"}, busy,      1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #3;
        check("rst_Q",    Q,         8'h00);
        check("rst_R",    R,         8'h00);
        check("rst_busy", busy,      1'b0);
        check("rst_done", done,      1'b0);
        check("rst_dz",   divByZero, 1'b0);
        check("rst_ovf",  overflow,  1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_op("u200_7",  8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 9, 0);
        run_op("u80_ff",  8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 9, 0);
        run_op("uff_01",  8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 9, 0);
        run_op("u07_c8",  8'h07, 8'hC8, 1'b0, 8'h00, 8'h07, 1'b0, 1'b0, 9, 0);
        run_op("uff_ff",  8'hFF, 8'hFF, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 9, 0);
        run_op("dz55",    8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b0, 1, 0);
        run_op("dz90s",   8'h90, 8'h00, 1'b1, 8'hFF, 8'h90, 1'b1, 1'b0, 1, 0);
`ifdef DIVIDER_SIGNED_EN
        run_op("sm100_7", 8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 9, 0);
        run_op("s100_m7", 8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b0, 9, 0);
        run_op("s80_ff",  8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 9, 0);
        run_op("s80_01",  8'h80, 8'h01, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 9, 0);
        run_op("sm7_2",   8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, 9, 0);
`else
        run_op("sm100_7", 8'h9C, 8'h07, 1'b1, 8'h16, 8'h02, 1'b0, 1'b0, 9, 0);
        run_op("s100_m7", 8'h64, 8'hF9, 1'b1, 8'h00, 8'h64, 1'b0, 1'b0, 9, 0);
        run_op("s80_ff",  8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 1'b0, 9, 0);
        run_op("s80_01",  8'h80, 8'h01, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 9, 0);
        run_op("sm7_2",   8'hF9, 8'h02, 1'b1, 8'h7C, 8'h01, 1'b0, 1'b0, 9, 0);
`endif

        // start pulsed again while busy is ignored; the following start is
        // raised in the done cycle and must be accepted at the next edge.
        run_op("repulse", 8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 9, 2);
        run_op("donecyc", 8'h64, 8'h0A, 1'b0, 8'h0A, 8'h00, 1'b0, 1'b0, 9, 0);
        run_op("u200_7b", 8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 9, 0);

        // Asynchronous reset in the fourth cycle of an operation.
        A       = 8'hC8;
        B       = 8'h07;
        divMode = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_Q",    Q,         8'h00);
        check("arst_R",    R,         8'h00);
        check("arst_busy", busy,      1'b0);
        check("arst_done", done,      1'b0);
        check("arst_dz",   divByZero, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("arst_nodone", done, 1'b0);
        end
        #2 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_nodone", done, 1'b0);
        end
        run_op("post_rst", 8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 9, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
